pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised elastic pipeline stage that replaces the fixed, always-advancing stage registers between EX and ME, and later between other stages. It carries an opaque payload of DATA_W bits under a valid/ready handshake. It adds what the fixed stage lacks: back-pressure, a 2-entry skid buffer that breaks the combinational ready path, synchronous flush for branch/exception kill, and a saturating stall counter for performance debug.

## Interface
Parameters:
- DATA_W, 108, payload width (EX/ME bundle: ALU result 32 + store data 32 + rd 5 + wb_ctrl 2 + we_reg 1 + we_mem 1 + ls_type 3 + PC 32)
- SKID_EN, 1, 1 = 2-entry skid with registered in_ready; 0 = single entry with combinational ready pass-through
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_data  out  DATA_W  head payload
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- The input fires when in_valid && in_ready. The output fires when out_valid && out_ready.
- Storage is a main register (head, drives out_data) and a skid register. State is EMPTY(0), ONE(1) or FULL(2). occupancy equals the state encoding.
- Priority order: rst > flush > normal transitions.
- SKID_EN=1:
  - in_ready = (state != FULL) && !rst. This is decoded from registered state only.
  - EMPTY: input fires → main <= in_data, go to ONE.
  - ONE:
    - input and output both fire → main <= in_data, stay in ONE.
    - output fires only → EMPTY.
    - input fires only → skid <= in_data, go to FULL.
    - neither fires → hold.
  - FULL: in_ready=0. Output fires → main <= skid, go to ONE. Otherwise hold.
- SKID_EN=0:
  - Single entry, states EMPTY and ONE only.
  - in_ready = (!out_valid || out_ready) && !rst.
  - The input fires → main <= in_data.
  - The output fires without input → EMPTY.
  - FULL is unreachable.
- out_valid = (state != EMPTY).
- flush:
  - Next state EMPTY. Any input firing in the same cycle is discarded.
  - Payload registers keep their old contents; they are don't-care while invalid.
  - stall_cnt is unaffected.
- stall_cnt:
  - Increments when out_valid && !out_ready. Holds at 2^CNT_W−1.
  - Cleared only by rst. flush does not clear it.
- Payload is passed bit-exact. No interpretation of fields.

## Timing
- Reset values: state EMPTY, out_valid 0, occupancy 0, out_data 0, skid 0, stall_cnt 0, in_ready 0 while rst=1.
- In the first cycle after rst deasserts, in_ready=1.
- Latency: 1 cycle. A beat accepted at edge N is on out_data with out_valid=1 after edge N.
- Throughput: 1 beat/cycle sustained when out_ready is held at 1, in both modes.
- SKID_EN=1: no combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Ordering: beats leave in acceptance order. No beat is duplicated or dropped except by flush.
- Simultaneous flush and output fire: the downstream consumes the head this cycle. The stage is empty afterwards.
- rst asserted mid-operation: all held entries are discarded at the next edge, regardless of handshakes.

## Structure
- Shared package pipe_pkg:
  - Occupancy localparams OCC_EMPTY/OCC_ONE/OCC_FULL.
  - EXME_W = 108.
  - Field offset constants for the EX/ME bundle (ALU_LSB, WDATA_LSB, RD_LSB, WB_LSB, WEREG_BIT, WEMEM_BIT, LS_LSB, PC_LSB).
- Sub-module sat_counter (params W; ports clk, rst, inc, count) holds the saturating stall counter. It is reusable by other stages.
- The EX/ME instance packs and unpacks the bundle at its boundary using the pipe_pkg offsets.

## Test plan
- Reset then stream: after rst, present beats 0x1…0x5 on consecutive cycles with out_ready=1 → identical sequence on out_data one cycle later; occupancy stays 1; stall_cnt=0.
- Back-pressure fill (SKID_EN=1): out_ready=0, send A then B → occupancy 2, in_ready=0, out_data=A. Raise out_ready → A, then B on successive cycles, then out_valid=0.
- Simultaneous in/out in ONE: head A, out_ready=1, input C → next cycle out_data=C, occupancy 1.
- Flush with FULL and a concurrent input beat → next cycle out_valid=0, occupancy 0, the concurrent beat never appears; stall_cnt unchanged.
- Stall counter saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays there; only rst clears it.
- SKID_EN=0: out_ready toggled 1,0,1 with continuous input → in_ready follows out_ready in the same cycle; occupancy never exceeds 1; order preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy encoding, stage FSM states and
// the EX/ME bundle layout used when packing the payload at a stage boundary.
package pipe_pkg;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } stage_state_e;

  localparam int EXME_W = 108;

  // EX/ME bundle layout, LSB first
  localparam int ALU_LSB   = 0;
  localparam int WDATA_LSB = 32;
  localparam int RD_LSB    = 64;
  localparam int WB_LSB    = 69;
  localparam int WEREG_BIT = 71;
  localparam int WEMEM_BIT = 72;
  localparam int LS_LSB    = 73;
  localparam int PC_LSB    = 76;

  function automatic logic [EXME_W-1:0] pack_exme(
    input logic [31:0] alu,
    input logic [31:0] wdata,
    input logic [4:0]  rd,
    input logic [1:0]  wb,
    input logic        we_reg,
    input logic        we_mem,
    input logic [2:0]  ls,
    input logic [31:0] pc
  );
    logic [EXME_W-1:0] b;
    b = '0;
    b[ALU_LSB +: 32]   = alu;
    b[WDATA_LSB +: 32] = wdata;
    b[RD_LSB +: 5]     = rd;
    b[WB_LSB +: 2]     = wb;
    b[WEREG_BIT]       = we_reg;
    b[WEMEM_BIT]       = we_mem;
    b[LS_LSB +: 3]     = ls;
    b[PC_LSB +: 32]    = pc;
    return b;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset. Shared by pipeline
// stages for stall/performance statistics.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with optional 2-entry skid buffer,
// synchronous flush and a saturating stall counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 108,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state_q;

  // With the skid buffer, ready comes from registered state only
  assign in_ready = SKID_EN ? ((state_q != ST_FULL) && !rst)
                            : ((!out_valid || out_ready) && !rst);

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (SKID_EN) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end else begin
      if (in_fire) begin
        main_d  = in_data;
        state_d = ST_ONE;
      end else if (out_fire) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule
